scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Scan-test initiator that drives one chain of scanff cells (CK/SD/SI/SE/Q).
- Per test: latches a pattern, shifts it into the chain, pulses one functional capture cycle, shifts the response back out, and compares it against an expected vector.
- Sits between the test sequencer/TAP logic and the chain's SE/SI/SO pins, clocked by the same clock as the chain.

Parameters:
- CHAIN_LEN, 16, number of scan cells in the chain (min 2).
- CNT_W, $clog2(CHAIN_LEN)+1, width of the shift counter.

Ports:
- clock  input  1  chain/controller clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a test; sampled only in IDLE.
- pattern_in  input  CHAIN_LEN  stimulus; bit k is destined for cell k (cell 0 is nearest scan_in).
- expected_in  input  CHAIN_LEN  expected captured value of cell k at bit k.
- scan_en  output  1  to all cells' SE; 1 = shift, 0 = functional capture.
- scan_in  output  1  to SI of cell 0.
- scan_out  input  1  Q of cell CHAIN_LEN-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when response_out and pass are updated.
- response_out  output  CHAIN_LEN  captured chain contents; bit k = cell k.
- pass  output  1  response_out == latched expected_in; valid from done.

Behaviour:
- Reset (async, any state): state=IDLE, count=0, scan_en=0, scan_in=0, busy=0, done=0, response_out=0, pass=0, pattern/expected registers cleared. An in-flight test is discarded; the chain contents are left as-is.
- States: IDLE, LOAD, CAPTURE, UNLOAD, DONE. Outputs are Moore: decoded from registered state, count and latched vectors only.
- IDLE: scan_en=0, scan_in=0. On the edge with start=1: latch pattern_in and expected_in, set count=0, go to LOAD.
- LOAD: scan_en=1, scan_in=pattern_q[CHAIN_LEN-1-count].
  - MSB shifts first, so after CHAIN_LEN shift edges cell k holds pattern bit k.
  - count increments each cycle; after the cycle with count=CHAIN_LEN-1, go to CAPTURE with count=0.
- CAPTURE: exactly one cycle, scan_en=0, scan_in=0. The chain loads SD on the closing edge. Next state is UNLOAD.
- UNLOAD: scan_en=1, scan_in=0.
  - In the cycle with count=i, register response_q[CHAIN_LEN-1-i] <= scan_out on the closing edge. scan_out is sampled before the shift takes effect.
  - After count=CHAIN_LEN-1, go to DONE.
- DONE: one cycle.
  - done=1, scan_en=0.
  - response_out=response_q, and pass=(response_q==expected_q) are valid this cycle.
  - Next state is IDLE.
- response_out and pass hold until the next DONE. They are not cleared by a new start.
- Timing, with start sampled at edge 0:
  - LOAD spans cycles 1..CHAIN_LEN.
  - CAPTURE is cycle CHAIN_LEN+1.
  - UNLOAD spans cycles CHAIN_LEN+2..2*CHAIN_LEN+1.
  - done=1 in cycle 2*CHAIN_LEN+2.
  - The earliest next start is accepted at the edge ending DONE+1 (IDLE).
- start while busy=1 is ignored; no queueing.
- pattern_in/expected_in changes after the accepting edge have no effect on the running test.
- Counter: the width rules prevent wrap; count never exceeds CHAIN_LEN-1.
- Unused state encodings recover to IDLE on the next edge.

Test Plan:
- Reset mid-LOAD (CHAIN_LEN=4, assert reset in LOAD cycle 2) -> scan_en, busy and done drop immediately, with no clock edge needed. After release, IDLE holds and start is accepted normally.
- CHAIN_LEN=4, behavioural chain with SD=Q (capture holds), pattern_in=4'b1011:
  - scan_in sequence in LOAD is 1,1,0,1; scan_en is 1,1,1,1,0,1,1,1,1.
  - done appears in cycle 10; response_out=4'b1011.
  - With expected_in=4'b1011, pass=1.
- Same setup but SD=~Q, pattern_in=4'b1011, expected_in=4'b0100 -> response_out=4'b0100, pass=1. With expected_in=4'b0101 instead, pass=0.
- Single-cell fault: force chain cell 2 stuck-at-0, pattern_in=4'b1111, SD=Q -> response_out=4'b1011, pass=0.
- Start pulsed during UNLOAD, and pattern_in changed during LOAD -> exactly one done pulse. Response reflects only the originally latched pattern, and busy falls the cycle after done.
- Back-to-back: start held high continuously -> tests repeat with one IDLE cycle between DONE and the next LOAD. response_out updates only in DONE cycles.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan-test initiator for a single chain of scan flops.
// Each test latches a stimulus, shifts it in MSB first, pulses one functional
// capture cycle, shifts the response back out and compares it with the
// latched expected vector. All outputs are registered.
//
// Handshake: start is a level sampled only while the controller is idle
// (busy=0). A test begins on the first rising edge that sees start=1 in IDLE.
// While busy=1 start is ignored and nothing is queued. done is a one-cycle
// pulse, and response_out and pass are valid from that cycle until the next
// done.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expected_in,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response_out,
    output logic                 pass,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [CHAIN_LEN-1:0] pattern_q;
    logic [CHAIN_LEN-1:0] expected_q;
    logic [CHAIN_LEN-1:0] response_q;

    // Stimulus bit for the next LOAD cycle sits at the top of the shifted
    // pattern: bit CHAIN_LEN-2-count of the latched pattern.
    logic [CHAIN_LEN-1:0] pat_next;
    // The first unloaded bit belongs to the cell farthest from scan_in, so
    // shifting samples in from the bottom lands each one at its cell index.
    logic [CHAIN_LEN-1:0] resp_next;

    assign pat_next  = pattern_q << (count + ONE);
    assign resp_next = {response_q[CHAIN_LEN-2:0], scan_out};
    assign dbg_state = state;

    // Controller FSM: next state, shift counter, latched vectors and all
    // registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            count        <= '0;
            pattern_q    <= '0;
            expected_q   <= '0;
            response_q   <= '0;
            scan_en      <= 1'b0;
            scan_in      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            response_out <= '0;
            pass         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    scan_en <= 1'b0;
                    scan_in <= 1'b0;
                    busy    <= 1'b0;
                    if (start) begin
                        pattern_q  <= pattern_in;
                        expected_q <= expected_in;
                        count      <= '0;
                        state      <= S_LOAD;
                        scan_en    <= 1'b1;
                        scan_in    <= pattern_in[CHAIN_LEN-1];
                        busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (count == LAST) begin
                        count   <= '0;
                        state   <= S_CAPTURE;
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                    end else begin
                        count   <= count + ONE;
                        scan_in <= pat_next[CHAIN_LEN-1];
                    end
                end
                S_CAPTURE: begin
                    state   <= S_UNLOAD;
                    scan_en <= 1'b1;
                    scan_in <= 1'b0;
                end
                S_UNLOAD: begin
                    response_q <= resp_next;
                    if (count == LAST) begin
                        count        <= '0;
                        state        <= S_DONE;
                        scan_en      <= 1'b0;
                        done         <= 1'b1;
                        response_out <= resp_next;
                        pass         <= (resp_next == expected_q);
                    end else begin
                        count <= count + ONE;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    scan_en <= 1'b0;
                    scan_in <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    count   <= '0;
                    busy    <= 1'b0;
                    scan_en <= 1'b0;
                    scan_in <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 4-cell behavioural scan chain.
// A timeline model predicts every output from the cycle offset since the
// accepting edge; directed tests add hand-computed literal expectations.
module tb_scan_chain_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int T_END = 2 * N + 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] pattern_in;
    logic [N-1:0] expected_in;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic         busy;
    logic         done;
    logic [N-1:0] response_out;
    logic         pass;
    logic [2:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pattern_in   (pattern_in),
        .expected_in  (expected_in),
        .scan_en      (scan_en),
        .scan_in      (scan_in),
        .scan_out     (scan_out),
        .busy         (busy),
        .done         (done),
        .response_out (response_out),
        .pass         (pass),
        .dbg_state    (dbg_state)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Behavioural chain: mode 0 captures SD=Q, mode 1 SD=~Q, mode 2 SD=Q
    // except cell 2 which always captures 0.
    logic [N-1:0] cq = '0;
    int           mode = 0;
    assign scan_out = cq[N-1];

    always @(posedge clock) begin
        if (scan_en) begin
            cq <= {cq[N-2:0], scan_in};
        end else if (mode == 1) begin
            cq <= ~cq;
        end else if (mode == 2) begin
            cq <= cq & ~(N'(1) << 2);
        end
    end

    // What the chain hands back after one capture of pattern p.
    function automatic logic [N-1:0] captured(input logic [N-1:0] p, input int md);
        logic [N-1:0] r;
        r = p;
        if (md == 1) r = ~p;
        if (md == 2) r[2] = 1'b0;
        return r;
    endfunction

    // Timeline model: t=0 idle, t=1..2N+2 are the cycles of a running test.
    int           t;
    logic [N-1:0] m_pat;
    logic [N-1:0] m_exp;
    logic [N-1:0] m_resp;
    logic         m_pass;
    int           m_mode;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            t      <= 0;
            m_pat  <= '0;
            m_exp  <= '0;
            m_resp <= '0;
            m_pass <= 1'b0;
            m_mode <= 0;
        end else if (t == 0) begin
            if (start) begin
                t      <= 1;
                m_pat  <= pattern_in;
                m_exp  <= expected_in;
                m_mode <= mode;
            end
        end else if (t == T_END) begin
            t <= 0;
        end else begin
            if (t == T_END - 1) begin
                m_resp <= captured(m_pat, m_mode);
                m_pass <= (captured(m_pat, m_mode) == m_exp);
            end
            t <= t + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        logic         e_en;
        logic         e_in;
        logic [N-1:0] sh;
        if (reset === 1'b0) begin
            e_en = ((t >= 1) && (t <= N)) || ((t >= N + 2) && (t <= 2 * N + 1));
            e_in = 1'b0;
            if ((t >= 1) && (t <= N)) begin
                sh   = m_pat >> (N - t);
                e_in = sh[0];
            end
            chk("scan_en", 32'(scan_en), 32'(e_en));
            chk("scan_in", 32'(scan_in), 32'(e_in));
            chk("busy", 32'(busy), 32'(t != 0));
            chk("done", 32'(done), 32'(t == T_END));
            chk("response_out", 32'(response_out), 32'(m_resp));
            chk("pass", 32'(pass), 32'(m_pass));
        end
    end

    logic [N-1:0] sin_seq;
    logic [8:0]   sen_seq;
    int           done_cyc;

    // Run one test from IDLE and check the done cycle and results literally.
    task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] exp,
                            input int md, input logic [N-1:0] want_resp,
                            input logic want_pass);
        int cyc;
        @(negedge clock);
        pattern_in  = pat;
        expected_in = exp;
        mode        = md;
        start       = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start   = 1'b0;
        cyc     = 1;
        sin_seq = '0;
        sen_seq = '0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc <= N) sin_seq = {sin_seq[N-2:0], scan_in};
            if (cyc <= 2 * N + 1) sen_seq = {sen_seq[7:0], scan_en};
            @(negedge clock);
            cyc++;
        end
        done_cyc = cyc;
        chk("done_cycle", 32'(cyc), 32'd10);
        chk("lit_response", 32'(response_out), 32'(want_resp));
        chk("lit_pass", 32'(pass), 32'(want_pass));
    endtask

    initial begin
        int dn;
        reset       = 1'b1;
        start       = 1'b0;
        pattern_in  = '0;
        expected_in = '0;
        repeat (2) @(negedge clock);
        chk("rst_scan_en", 32'(scan_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_response", 32'(response_out), 32'd0);
        #2 reset = 1'b0;

        // Reset in the second LOAD cycle drops outputs without a clock edge.
        @(negedge clock);
        pattern_in = 4'b1011;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midload_scan_en", 32'(scan_en), 32'd0);
        chk("midload_busy", 32'(busy), 32'd0);
        chk("midload_done", 32'(done), 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_reset_idle", 32'(busy), 32'd0);

        // Hold capture: stimulus comes back unchanged.
        run_test(4'b1011, 4'b1011, 0, 4'b1011, 1'b1);
        chk("lit_scan_in_seq", 32'(sin_seq), 32'b1011);
        chk("lit_scan_en_seq", 32'(sen_seq), 32'b111101111);

        // Inverting capture.
        run_test(4'b1011, 4'b0100, 1, 4'b0100, 1'b1);
        run_test(4'b1011, 4'b0101, 1, 4'b0100, 1'b0);

        // Cell 2 captures 0.
        run_test(4'b1111, 4'b1111, 2, 4'b1011, 1'b0);

        // Input changes during LOAD and a start pulse during UNLOAD.
        @(negedge clock);
        mode        = 0;
        pattern_in  = 4'b0110;
        expected_in = 4'b0110;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dn    = 0;
        for (int c = 1; c < 20; c++) begin
            if (c == 2) begin
                pattern_in  = 4'b1001;
                expected_in = 4'b1001;
            end
            start = (c == 7);
            if (done === 1'b1) dn++;
            @(negedge clock);
        end
        start = 1'b0;
        chk("single_done", 32'(dn), 32'd1);
        chk("orig_pattern_resp", 32'(response_out), 32'b0110);
        chk("orig_pattern_pass", 32'(pass), 32'd1);

        // start held high: tests repeat with one idle cycle in between.
        @(negedge clock);
        mode        = 1;
        pattern_in  = 4'b0011;
        expected_in = 4'b1100;
        start       = 1'b1;
        dn          = 0;
        for (int c = 0; c < 2 * (T_END + 1); c++) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(dn), 32'd2);
        chk("b2b_resp", 32'(response_out), 32'b1100);

        repeat (T_END + 4) @(negedge clock);
        chk("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
